// File: rtl/qsys_multi_timer_pkg.sv
// Shared register map, control/status bit positions and per-channel write-strobe
// decode for the multi-channel interval timer.
package qsys_multi_timer_pkg;

  // Channel register offsets within a bank
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  // Global bank register offsets
  localparam logic [1:0] GREG_IRQ_PEND = 2'd0;
  localparam logic [1:0] GREG_PRESCALE = 2'd1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
  } ch_wr_t;

  function automatic ch_wr_t decode_wr(input logic hit, input logic [1:0] reg_sel);
    ch_wr_t w;
    w.status  = hit && (reg_sel == REG_STATUS);
    w.control = hit && (reg_sel == REG_CONTROL);
    w.period  = hit && (reg_sel == REG_PERIOD);
    w.snap    = hit && (reg_sel == REG_SNAP);
    return w;
  endfunction

endpackage

// File: rtl/qsys_multi_timer_if.sv
// Avalon-MM slave bus of the timer: one 32-bit port, active-low write, registered read.
interface qsys_multi_timer_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  chipselect;
  logic [ADDR_WIDTH-1:0] address;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/qsys_multi_timer_channel.sv
// One timer channel: down-counter, PERIOD, CONTROL, RUN/TO flags, snapshot and
// the channel's own read mux. Counts only on the shared prescaler tick.
module qsys_multi_timer_channel
  import qsys_multi_timer_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  ch_wr_t                   wr,
  input  logic [COUNTER_WIDTH-1:0] wdata,
  input  logic [1:0]               reg_sel,
  output logic [31:0]              rdata,
  output logic                     irq_out
);

  localparam logic [COUNTER_WIDTH-1:0] RESET_VAL = COUNTER_WIDTH'(DEFAULT_PERIOD);

  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH-1:0] period;
  logic [COUNTER_WIDTH-1:0] snap;
  logic [3:0]               ctrl;
  logic                     run;
  logic                     to;
  logic                     reload_pend;
  logic                     terminal;
  logic                     start_wr;
  logic                     stop_wr;

  // A pending PERIOD reload overrides the tick, so it also suppresses the timeout.
  assign terminal = run && tick && (count == '0) && !reload_pend;
  assign start_wr = wr.control && wdata[CTRL_START];
  assign stop_wr  = wr.control && wdata[CTRL_STOP];

  // NOTE: non-blocking assignments let every register here see pre-edge values,
  // which is what makes SNAP capture the counter as it was before this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= RESET_VAL;
      period      <= RESET_VAL;
      snap        <= '0;
      ctrl        <= '0;
      run         <= 1'b0;
      to          <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      reload_pend <= wr.period;
      if (wr.period)  period <= wdata;
      if (wr.control) ctrl   <= wdata[3:0];
      if (wr.snap)    snap   <= count;

      if (start_wr)                            run <= 1'b1;
      else if (stop_wr)                        run <= 1'b0;
      else if (reload_pend)                    run <= 1'b0;
      else if (terminal && !ctrl[CTRL_CONT])   run <= 1'b0;

      if (reload_pend)         count <= period;
      else if (run && tick)    count <= (count == '0) ? period : count - 1'b1;

      // Set beats clear so a timeout landing on a STATUS write is never lost.
      if (terminal)            to <= 1'b1;
      else if (wr.status)      to <= 1'b0;
    end
  end

  assign irq_out = to && ctrl[CTRL_ITO];

  // NOTE: default assignment first keeps this mux free of inferred latches.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[STAT_RUN] = run;
        rdata[STAT_TO]  = to;
      end
      REG_CONTROL: rdata[3:0] = ctrl;
      REG_PERIOD:  rdata      = 32'(period);
      REG_SNAP:    rdata      = 32'(snap);
      default:     rdata      = '0;
    endcase
  end

endmodule

// File: rtl/qsys_multi_timer.sv
// N-channel interval timer on one Avalon-MM slave: address decode, shared
// prescaler, channel array, global registers, registered read mux and IRQ OR.
module qsys_multi_timer
  import qsys_multi_timer_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int COUNTER_WIDTH  = 32,
  parameter  int DEFAULT_PERIOD = 49999,
  localparam int ADDR_WIDTH     = $clog2(NUM_CH + 1) + 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  qsys_multi_timer_if.slave     bus,
  output logic                  irq,
  output logic [NUM_CH-1:0]     irq_vec
);

  localparam int BW = ADDR_WIDTH - 2;

  logic [BW-1:0] bank;
  logic [1:0]    reg_sel;
  logic          wr_en;
  logic          glob_sel;
  logic          wr_prescale;
  logic [15:0]   prescale;
  logic [15:0]   pcnt;
  logic          tick;
  logic [31:0]   chan_rdata [NUM_CH];
  logic [31:0]   rd_next;
  logic          unused_wdata;

  assign bank         = bus.address[ADDR_WIDTH-1:2];
  assign reg_sel      = bus.address[1:0];
  assign wr_en        = bus.chipselect && !bus.write_n;
  assign glob_sel     = (bank == BW'(NUM_CH));
  assign wr_prescale  = wr_en && glob_sel && (reg_sel == GREG_PRESCALE);
  assign unused_wdata = ^bus.writedata;

  // Tick on the last prescale count; a PRESCALE write restarts the phase.
  assign tick = (pcnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      pcnt     <= '0;
    end else if (wr_prescale) begin
      prescale <= bus.writedata[15:0];
      pcnt     <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_wr_t ch_wr;
    assign ch_wr = decode_wr(wr_en && (bank == BW'(i)), reg_sel);

    qsys_multi_timer_channel #(
      .COUNTER_WIDTH  (COUNTER_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .wr      (ch_wr),
      .wdata   (bus.writedata[COUNTER_WIDTH-1:0]),
      .reg_sel (reg_sel),
      .rdata   (chan_rdata[i]),
      .irq_out (irq_vec[i])
    );
  end

  assign irq = |irq_vec;

  // Banks above the global bank fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bank == BW'(i)) rd_next = chan_rdata[i];
    end
    if (glob_sel) begin
      case (reg_sel)
        GREG_IRQ_PEND: rd_next = 32'(irq_vec);
        GREG_PRESCALE: rd_next = 32'(prescale);
        default:       rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_next;
  end

endmodule

// File: tb/tb_qsys_multi_timer.sv
// Directed bench for qsys_multi_timer: a 4-channel/32-bit instance for timing and
// corner cases, and an 8-channel/16-bit instance for width and IRQ_PEND checks.
module tb_qsys_multi_timer;

  localparam int AW_A = $clog2(4 + 1) + 2;
  localparam int AW_B = $clog2(8 + 1) + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       irq_a, irq_b;
  logic [3:0] irq_vec_a;
  logic [7:0] irq_vec_b;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  qsys_multi_timer_if #(.ADDR_WIDTH(AW_A)) bus_a ();
  qsys_multi_timer_if #(.ADDR_WIDTH(AW_B)) bus_b ();

  qsys_multi_timer #(.NUM_CH(4), .COUNTER_WIDTH(32), .DEFAULT_PERIOD(49999)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .irq(irq_a), .irq_vec(irq_vec_a)
  );

  qsys_multi_timer #(.NUM_CH(8), .COUNTER_WIDTH(16), .DEFAULT_PERIOD(49999)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .irq(irq_b), .irq_vec(irq_vec_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [AW_A-1:0] aa(input int bank, input int r);
    return AW_A'(bank * 4 + r);
  endfunction

  function automatic logic [AW_B-1:0] ab(input int bank, input int r);
    return AW_B'(bank * 4 + r);
  endfunction

  // Bus tasks are entered at a negedge and return at the following negedge.
  task automatic wr_a(input logic [AW_A-1:0] a, input logic [31:0] d);
    bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    @(negedge clk);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
  endtask

  task automatic rd_a(input logic [AW_A-1:0] a, output logic [31:0] d);
    bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
    @(negedge clk);
    d = bus_a.readdata;
    bus_a.chipselect = 1'b0;
  endtask

  task automatic wr_b(input logic [AW_B-1:0] a, input logic [31:0] d);
    bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    @(negedge clk);
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic rd_b(input logic [AW_B-1:0] a, output logic [31:0] d);
    bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
    @(negedge clk);
    d = bus_b.readdata;
    bus_b.chipselect = 1'b0;
  endtask

  task automatic wait_irq_a(input string tag, input int ch, input int bound, output int at);
    bit seen;
    seen = 1'b0;
    at = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (irq_vec_a[ch]) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: irq_vec[%0d] still 0 after %0d cycles, expected 1", tag, ch, bound);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] d;
    int t0, t1, t2;

    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = '0; bus_a.writedata = '0;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.address = '0; bus_b.writedata = '0;
    repeat (3) @(negedge clk);
    check("rst readdata", bus_a.readdata, 32'd0);
    check("rst irq", 32'(irq_a), 32'd0);
    reset_n = 1'b1;

    // 1: reset state
    rd_a(aa(0, 0), d); check("rst ch0 status", d, 32'h0);
    rd_a(aa(0, 2), d); check("rst ch0 period", d, 32'd49999);
    rd_a(aa(0, 3), d); check("rst ch0 snap", d, 32'h0);
    rd_a(aa(0, 1), d); check("rst ch0 control", d, 32'h0);
    rd_a(aa(4, 1), d); check("rst prescale", d, 32'h0);
    check("rst irq_vec", 32'(irq_vec_a), 32'h0);
    wr_a(aa(4, 1), 32'h0001_2345);
    rd_a(aa(4, 1), d); check("prescale 16b", d, 32'h0000_2345);
    wr_a(aa(4, 1), 32'h0);
    rd_a(aa(4, 2), d); check("global reg2", d, 32'h0);

    // 2: ch1 continuous, period 9 -> TO every 10 cycles
    wr_a(aa(1, 2), 32'd9);
    wr_a(aa(1, 1), 32'h7);
    wait_irq_a("ch1 first to", 1, 40, t0);
    check("ch1 irq", 32'(irq_a), 32'd1);
    check("ch1 irq_vec", 32'(irq_vec_a), 32'h2);
    wr_a(aa(1, 0), 32'h0);
    check("ch1 clear irq", 32'(irq_a), 32'd0);
    wait_irq_a("ch1 second to", 1, 40, t1);
    check("ch1 interval", 32'(t1 - t0), 32'd10);
    wr_a(aa(1, 0), 32'h0);
    wait_irq_a("ch1 third to", 1, 40, t2);
    check("ch1 interval2", 32'(t2 - t1), 32'd10);
    wr_a(aa(1, 1), 32'h8);
    wr_a(aa(1, 0), 32'h0);
    check("ch1 stopped irq", 32'(irq_a), 32'd0);

    // 3: ch2 one-shot, period 4; START lands in the force-reload cycle
    wr_a(aa(2, 2), 32'd4);
    wr_a(aa(2, 1), 32'h4);
    for (int k = 0; k < 5; k++) begin
      rd_a(aa(2, 0), d); check($sformatf("ch2 running %0d", k), d, 32'h2);
    end
    rd_a(aa(2, 0), d); check("ch2 timed out", d, 32'h1);
    wr_a(aa(2, 3), 32'h0);
    rd_a(aa(2, 3), d); check("ch2 reloaded", d, 32'd4);
    wr_a(aa(2, 0), 32'h0);
    repeat (20) @(negedge clk);
    rd_a(aa(2, 0), d); check("ch2 no second to", d, 32'h0);

    // 4: prescale 3, ch0 period 1 -> TO every 8 cycles; prescale rewrite delays it
    wr_a(aa(4, 1), 32'd3);
    wr_a(aa(0, 2), 32'd1);
    wr_a(aa(0, 1), 32'h7);
    wait_irq_a("ch0 first to", 0, 40, t0);
    wr_a(aa(0, 0), 32'h0);
    wait_irq_a("ch0 second to", 0, 40, t1);
    check("ch0 interval", 32'(t1 - t0), 32'd8);
    wr_a(aa(0, 0), 32'h0);
    wr_a(aa(4, 1), 32'd3);
    wait_irq_a("ch0 after prescale rewrite", 0, 40, t2);
    check("ch0 phase restart", 32'(t2 - t1), 32'd10);
    wr_a(aa(0, 1), 32'h8);
    wr_a(aa(0, 0), 32'h0);
    wr_a(aa(4, 1), 32'd0);
    check("ch0 masked", 32'(irq_vec_a), 32'h0);

    // 5: corner cases on ch3, period 2 -> TO every 3 cycles
    wr_a(aa(3, 2), 32'd2);
    wr_a(aa(3, 1), 32'h7);
    wait_irq_a("ch3 first to", 3, 20, t0);
    wr_a(aa(3, 0), 32'h0);
    check("ch3 normal clear", 32'(irq_vec_a[3]), 32'd0);
    @(negedge clk);
    wr_a(aa(3, 0), 32'h0);
    check("ch3 set beats clear", 32'(irq_vec_a[3]), 32'd1);
    wr_a(aa(3, 1), 32'h8);
    rd_a(aa(3, 0), d); check("ch3 stop run", 32'(d[1]), 32'd0);
    wr_a(aa(3, 1), 32'hC);
    rd_a(aa(3, 0), d); check("ch3 start beats stop", 32'(d[1]), 32'd1);
    rd_a(aa(3, 1), d); check("ch3 control readback", d, 32'hC);
    wr_a(aa(3, 1), 32'h6);
    wr_a(aa(3, 2), 32'd100);
    @(negedge clk);
    wr_a(aa(3, 3), 32'h0);
    rd_a(aa(3, 3), d); check("ch3 forced reload", d, 32'd100);
    rd_a(aa(3, 0), d); check("ch3 period write stops", 32'(d[1]), 32'd0);

    // 6: snapshots while counting; START in reload cycle keeps RUN
    wr_a(aa(3, 2), 32'd50);
    wr_a(aa(3, 1), 32'h6);
    rd_a(aa(3, 0), d); check("ch3 start in reload", 32'(d[1]), 32'd1);
    wr_a(aa(3, 3), 32'h0);
    rd_a(aa(3, 3), d); check("ch3 snap a", d, 32'd49);
    repeat (3) @(negedge clk);
    wr_a(aa(3, 3), 32'h0);
    rd_a(aa(3, 3), d); check("ch3 snap b", d, 32'd44);
    wr_a(aa(3, 2), 32'd7);
    wr_a(aa(3, 3), 32'h0);
    rd_a(aa(3, 3), d); check("ch3 snap at reload", d, 32'd41);
    wr_a(aa(3, 1), 32'h8);
    wr_a(aa(3, 0), 32'h0);

    // 16-bit, 8-channel instance
    rd_b(ab(0, 2), d); check("b rst period", d, 32'h0000_C34F);
    wr_b(ab(5, 2), 32'h0001_2345);
    rd_b(ab(5, 2), d); check("b period 16b", d, 32'h0000_2345);
    wr_b(ab(5, 2), 32'h0);
    wr_b(ab(7, 2), 32'h0);
    wr_b(ab(2, 2), 32'h0);
    wr_b(ab(5, 1), 32'h7);
    wr_b(ab(7, 1), 32'h7);
    wr_b(ab(2, 1), 32'h6);
    repeat (3) @(negedge clk);
    rd_b(ab(8, 0), d); check("b irq_pend", d, 32'h0000_00A0);
    check("b irq_vec", 32'(irq_vec_b), 32'h0000_00A0);
    check("b irq", 32'(irq_b), 32'd1);
    rd_b(ab(12, 2), d); check("b unmapped bank", d, 32'h0);

    // Reset mid-count clears everything asynchronously
    wr_a(aa(1, 2), 32'd0);
    wr_a(aa(1, 1), 32'h7);
    wait_irq_a("ch1 before reset", 1, 20, t0);
    #2 reset_n = 1'b0;
    #1;
    check("async rst irq_a", 32'(irq_a), 32'd0);
    check("async rst irq_b", 32'(irq_b), 32'd0);
    check("async rst readdata", bus_b.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_a(aa(1, 2), d); check("post rst period", d, 32'd49999);
    rd_a(aa(1, 0), d); check("post rst status", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
